spi_controller: RTL and testbench

- SPI mode-0 write initiator: the controller end of the register-write link consumed by spi_peripheral.
- Accepts register-write requests (7-bit address, 8-bit data) over a valid/ready handshake.
- Serialises each request as one 16-bit frame on ncs/sclk/copi.
- Used in the on-chip self-test/loopback harness and as the bench driver model for the PWM register file.

---
 rtl/spi_controller.sv | 130 +++++++++++++
 tb/tb_spi_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 register-write initiator: serialises {1'b1, addr[6:0], data[7:0]}
// MSB first on ncs/sclk/copi, with every SPI output driven from a flop.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    GAP      = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic [3:0]  bit_cnt, bit_nxt;
  logic [15:0] shift, shift_nxt;
  logic        ready_nxt, busy_nxt, done_nxt, sclk_nxt, copi_nxt, ncs_nxt;
  logic        phase_end, accept;

  assign phase_end = (div_cnt == DIV_LAST);
  assign accept    = req_valid && req_ready;

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= 8'd0;
      bit_cnt   <= 4'd0;
      shift     <= 16'd0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      ncs       <= 1'b1;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      shift     <= shift_nxt;
      req_ready <= ready_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      sclk      <= sclk_nxt;
      copi      <= copi_nxt;
      ncs       <= ncs_nxt;
    end
  end

  // Next-state: every non-idle phase lasts exactly CLK_DIV cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept)    state_nxt = SETUP;    else state_nxt = IDLE;
      SETUP:    if (phase_end) state_nxt = SHIFT_HI; else state_nxt = SETUP;
      SHIFT_HI: if (phase_end) state_nxt = SHIFT_LO; else state_nxt = SHIFT_HI;
      SHIFT_LO: begin
        if (phase_end) begin
          if (bit_cnt == 4'd0) state_nxt = GAP;
          else                 state_nxt = SHIFT_HI;
        end else begin
          state_nxt = SHIFT_LO;
        end
      end
      GAP:      if (phase_end) state_nxt = IDLE;     else state_nxt = GAP;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values; outputs are derived from the next state
  // so that they line up with the state register cycle for cycle
  always_comb begin
    div_nxt   = (state == IDLE || phase_end) ? 8'd0 : div_cnt + 8'd1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    copi_nxt  = copi;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_nxt = {1'b1, req_addr, req_data};
          bit_nxt   = 4'd15;
          copi_nxt  = 1'b1;
        end else begin
          copi_nxt  = 1'b0;
        end
      end
      SHIFT_HI: begin
        // copi moves only on the falling sclk edge; bit 0 is held through the CS hold
        if (phase_end && bit_cnt != 4'd0) begin
          shift_nxt = shift << 4'd1;
          copi_nxt  = shift[14];
        end else begin
          shift_nxt = shift;
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          if (bit_cnt == 4'd0) copi_nxt = 1'b0;
          else                 bit_nxt  = bit_cnt - 4'd1;
        end else begin
          bit_nxt = bit_cnt;
        end
      end
      GAP:     copi_nxt = 1'b0;
      default: copi_nxt = copi;
    endcase
    ncs_nxt   = !(state_nxt == SETUP || state_nxt == SHIFT_HI || state_nxt == SHIFT_LO);
    sclk_nxt  = (state_nxt == SHIFT_HI);
    ready_nxt = (state_nxt == IDLE);
    busy_nxt  = (state != IDLE) && (state_nxt != IDLE);
    done_nxt  = (state == GAP) && (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed/random bench for spi_controller: an SPI wire monitor plus a
// register-file model of the peripheral, checked against request-side expectations.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, busy, done, sclk, copi, ncs;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       v2, ready2, busy2, done2, sclk2, copi2, ncs2;
  logic [6:0] a2;
  logic [7:0] d2;

  int n_chk = 0;
  int n_fail = 0;

  spi_controller #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done),
    .sclk(sclk), .copi(copi), .ncs(ncs));

  spi_controller #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(ready2),
    .req_addr(a2), .req_data(d2), .busy(busy2), .done(done2),
    .sclk(sclk2), .copi(copi2), .ncs(ncs2));

  always #5 clk = ~clk;

  // Monitor / peripheral model for the CLK_DIV=4 instance
  logic [15:0] bits_a = 16'd0, last_bits = 16'd0;
  int nb_a = 0, last_nb = 0, low_a = 0, last_low = 0, hi_a = 0, last_hi = 0;
  int frames_a = 0, done_cnt = 0;
  logic ncs_p = 1'b1, sclk_p = 1'b0;
  logic [7:0] regs [128];
  logic [7:0] exp_regs [128];
  initial for (int i = 0; i < 128; i++) begin regs[i] = 8'd0; exp_regs[i] = 8'd0; end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (ncs === 1'b0) begin
      if (ncs_p) begin bits_a = 16'd0; nb_a = 0; low_a = 0; last_hi = hi_a; end
      low_a++;
      if (sclk && !sclk_p) begin bits_a = {bits_a[14:0], copi}; nb_a++; end
      hi_a = 0;
    end else begin
      if (!ncs_p) begin
        frames_a++; last_bits = bits_a; last_nb = nb_a; last_low = low_a;
        if (nb_a == 16 && bits_a[15]) regs[bits_a[14:8]] = bits_a[7:0];
      end
      hi_a++;
    end
    ncs_p = ncs; sclk_p = sclk;
  end

  // Monitor for the CLK_DIV=2 instance: phase lengths and copi edge placement
  logic [15:0] bits_b = 16'd0;
  int nb_b = 0, low_b = 0, run_b = 0, run_bad = 0, copi_bad = 0;
  logic ncs2_p = 1'b1, sclk2_p = 1'b0, copi2_p = 1'b0;

  always @(negedge clk) begin
    if (ncs2 === 1'b0) begin
      if (ncs2_p) begin bits_b = 16'd0; nb_b = 0; low_b = 0; run_b = 1; end
      else if (sclk2 != sclk2_p) begin if (run_b != 2) run_bad++; run_b = 1; end
      else run_b++;
      low_b++;
      if (sclk2 && !sclk2_p) begin bits_b = {bits_b[14:0], copi2}; nb_b++; end
      if (copi2 != copi2_p && !ncs2_p && !(sclk2_p && !sclk2)) copi_bad++;
    end else if (!ncs2_p) begin
      if (run_b != 2) run_bad++;
    end
    ncs2_p = ncs2; sclk2_p = sclk2; copi2_p = copi2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_a(input logic [6:0] a, input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    req_valid = 1'b1; req_addr = a; req_data = d;
    while (req_ready !== 1'b1 && n < 400) begin step(); n++; end
    chk("accept_wait", 32'(n < 400), 32'd1);
    step();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, output int done_at, output int busy_cnt,
                           output int busy_first, output int busy_last, output int ready_bad);
    done_at = -1; busy_cnt = 0; busy_first = -1; busy_last = -1; ready_bad = 0;
    for (int k = 0; k < 400; k++) begin
      if (done === 1'b1) begin done_at = k; break; end
      if (busy === 1'b1) begin busy_cnt++; if (busy_first < 0) busy_first = k; busy_last = k; end
      if (req_ready !== 1'b0) ready_bad++;
      if (toggle) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = 7'($urandom);
        req_data  = 8'($urandom);
      end
      step();
    end
    if (toggle) req_valid = 1'b0;
  endtask

  // Expected frame from the write-request rule, in plain arithmetic
  function automatic logic [15:0] frame_of(input int a, input int d);
    return 16'(32768 + a * 256 + d);
  endfunction

  initial begin
    int dn, bc, bf, bl, rb, n, k;
    logic [6:0] a;
    logic [7:0] d;
    rst = 1'b1; req_valid = 1'b0; req_addr = 7'd0; req_data = 8'd0;
    v2 = 1'b0; a2 = 7'd0; d2 = 8'd0;
    step(); step();
    chk("rst_ncs", ncs, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_copi", copi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    rst = 1'b0;
    step(); step();

    // Basic frame with timing
    start_a(7'h00, 8'hFF, 1'b0);
    exp_regs[0] = 8'hFF;
    wait_done(1'b0, dn, bc, bf, bl, rb);
    chk("t1_done_at", dn, 136);
    chk("t1_busy_cnt", bc, 135);
    chk("t1_busy_first", bf, 1);
    chk("t1_busy_last", bl, 135);
    chk("t1_busy_at_done", busy, 1'b0);
    chk("t1_ready_busy", rb, 0);
    chk("t1_frame", last_bits, frame_of(0, 255));
    chk("t1_nbits", last_nb, 16);
    chk("t1_ncs_low", last_low, 132);
    step();
    chk("t1_done_pulse", done, 1'b0);

    // Peripheral register writes
    start_a(7'h04, 8'h80, 1'b0); exp_regs[4] = 8'h80;
    wait_done(1'b0, dn, bc, bf, bl, rb);
    chk("int_duty", regs[4], exp_regs[4]);
    start_a(7'h02, 8'h01, 1'b0); exp_regs[2] = 8'h01;
    wait_done(1'b0, dn, bc, bf, bl, rb);
    chk("int_en", regs[2], exp_regs[2]);

    // Back-to-back with req_valid held; second request presented during frame 1
    start_a(7'h01, 8'hA5, 1'b1); exp_regs[1] = 8'hA5;
    req_addr = 7'h03; req_data = 8'h3C;
    wait_done(1'b0, dn, bc, bf, bl, rb);
    chk("b2b_ready_at_done", req_ready, 1'b1);
    step();
    req_valid = 1'b0; exp_regs[3] = 8'h3C;
    chk("b2b_frame1", last_bits, frame_of(1, 165));
    chk("b2b_ncs_high", last_hi, 5);
    chk("b2b_ncs_low_now", ncs, 1'b0);
    wait_done(1'b0, dn, bc, bf, bl, rb);
    chk("b2b_frame2", last_bits, frame_of(3, 60));
    chk("b2b_reg1", regs[1], exp_regs[1]);
    chk("b2b_reg3", regs[3], exp_regs[3]);

    // Inputs toggled while busy
    a = 7'($urandom); d = 8'($urandom);
    start_a(a, d, 1'b0); exp_regs[a] = d;
    wait_done(1'b1, dn, bc, bf, bl, rb);
    chk("busy_ready", rb, 0);
    chk("busy_frame", last_bits, frame_of(int'(a), int'(d)));
    chk("busy_done_at", dn, 136);
    n = frames_a;
    repeat (20) step();
    chk("busy_no_extra", frames_a, n);
    chk("busy_idle_ncs", ncs, 1'b1);

    // Reset after the 7th rising sclk edge
    a = 7'h10; d = ~exp_regs[7'h10];
    start_a(a, d, 1'b0);
    k = 0;
    while (nb_a < 7 && k < 400) begin step(); k++; end
    chk("rst_mid_edges", nb_a, 7);
    n = done_cnt;
    rst = 1'b1;
    #1;
    chk("rstm_ncs", ncs, 1'b1);
    chk("rstm_sclk", sclk, 1'b0);
    chk("rstm_copi", copi, 1'b0);
    chk("rstm_busy", busy, 1'b0);
    chk("rstm_ready", req_ready, 1'b1);
    step(); step();
    rst = 1'b0;
    repeat (10) step();
    chk("rstm_no_done", done_cnt, n);
    chk("rstm_reg", regs[7'h10], exp_regs[7'h10]);
    d = 8'($urandom);
    start_a(a, d, 1'b0); exp_regs[a] = d;
    wait_done(1'b0, dn, bc, bf, bl, rb);
    chk("rstm_fresh_done", dn, 136);
    chk("rstm_fresh_reg", regs[7'h10], exp_regs[7'h10]);

    // Random frames
    for (int i = 0; i < 3; i++) begin
      a = 7'($urandom); d = 8'($urandom);
      start_a(a, d, 1'b0); exp_regs[a] = d;
      wait_done(1'b0, dn, bc, bf, bl, rb);
      chk("rnd_frame", last_bits, frame_of(int'(a), int'(d)));
      chk("rnd_reg", regs[a], exp_regs[a]);
      chk("rnd_low", last_low, 132);
    end

    // CLK_DIV=2 instance
    v2 = 1'b1; a2 = 7'h7F; d2 = 8'h5A;
    k = 0;
    while (ready2 !== 1'b1 && k < 100) begin step(); k++; end
    step();
    v2 = 1'b0;
    k = 0;
    while (done2 !== 1'b1 && k < 400) begin step(); k++; end
    chk("d2_done_at", k, 68);
    chk("d2_frame", bits_b, 16'hFF5A);
    chk("d2_nbits", nb_b, 16);
    chk("d2_ncs_low", low_b, 66);
    chk("d2_phase_len", run_bad, 0);
    chk("d2_copi_edges", copi_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
